// File: rtl/counter_pkg.sv
// Shared constants and parameter-legality check for the up/down modulo counter.
// Imported by the counter top level and its prescaler.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // MODULUS may equal 2**WIDTH, so the bound is computed in 64 bits.
  function automatic bit params_legal(input int width, input longint modulus, input int prescale);
    return (width >= 2) && (width <= 32) &&
           (modulus >= 2) && (modulus <= (longint'(1) << width)) &&
           (prescale >= 1) && (prescale <= 256);
  endfunction

endpackage

// File: rtl/count_prescaler.sv
// Step-enable generator: ticks on the PRESCALE-th enabled cycle, holds while en is low.
// With PRESCALE=1 the counter stays at 0 and tick follows en combinationally.
module count_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo-MODULUS counter with prescaler, wrap/saturate mode, parallel load,
// mirrored down count, terminal-count flag and a registered wrap pulse.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter int     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] ucount,
  output logic [WIDTH-1:0] dcount,
  output logic             tc,
  output logic             wrap
);

  if (!params_legal(WIDTH, MODULUS, PRESCALE)) begin : g_bad_params
    $error("updown_mod_counter: illegal WIDTH/MODULUS/PRESCALE combination");
  end

  // One extra bit so MODULUS = 2**WIDTH is representable.
  localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH-1:0] ucount_q;
  logic [WIDTH-1:0] ucount_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             step;
  logic [WIDTH:0]   cur_x;
  logic [WIDTH:0]   ld_x;
  logic [WIDTH:0]   inc_x;
  logic [WIDTH:0]   dec_x;

  // A load also restarts the prescale interval.
  count_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (step)
  );

  assign cur_x = {1'b0, ucount_q};
  assign ld_x  = {1'b0, load_val};
  assign inc_x = cur_x + 1'b1;
  assign dec_x = cur_x - 1'b1;

  always_comb begin
    ucount_d = ucount_q;
    wrap_d   = 1'b0;
    if (load) begin
      ucount_d = (ld_x >= MOD_X) ? WIDTH'(MAX_X) : load_val;
    end else if (step) begin
      if (up_dn == DIR_UP) begin
        if (cur_x == MAX_X) begin
          if (sat != MODE_SAT) begin
            ucount_d = '0;
            wrap_d   = 1'b1;
          end
        end else begin
          ucount_d = WIDTH'(inc_x);
        end
      end else begin
        if (cur_x == '0) begin
          if (sat != MODE_SAT) begin
            ucount_d = WIDTH'(MAX_X);
            wrap_d   = 1'b1;
          end
        end else begin
          ucount_d = WIDTH'(dec_x);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ucount_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      ucount_q <= ucount_d;
      wrap_q   <= wrap_d;
    end
  end

  assign ucount = ucount_q;
  assign wrap   = wrap_q;
  assign dcount = WIDTH'(MAX_X - cur_x);
  assign tc     = (up_dn == DIR_UP) ? (cur_x == MAX_X) : (cur_x == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed-vector bench: three counter instances (mod 10, mod 10 /3 prescale, mod 16)
// share one stimulus; each vector names the instance whose outputs it checks.
module tb_updown_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst      = 1'b1;
  logic       en       = 1'b0;
  logic       up_dn    = 1'b1;
  logic       sat      = 1'b0;
  logic       load     = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] ucount_a, dcount_a, ucount_p, dcount_p, ucount_m, dcount_m;
  logic       tc_a, wrap_a, tc_p, wrap_p, tc_m, wrap_m;

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat), .load(load),
    .load_val(load_val), .ucount(ucount_a), .dcount(dcount_a), .tc(tc_a), .wrap(wrap_a));

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut_p (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat), .load(load),
    .load_val(load_val), .ucount(ucount_p), .dcount(dcount_p), .tc(tc_p), .wrap(wrap_p));

  updown_mod_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) dut_m (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat), .load(load),
    .load_val(load_val), .ucount(ucount_m), .dcount(dcount_m), .tc(tc_m), .wrap(wrap_m));

  typedef struct {
    int         sel;   // 0: mod10, 1: mod10 prescale 3, 2: mod16
    logic       rst;
    logic       en;
    logic       up;
    logic       sat;
    logic       ld;
    logic [3:0] lv;
    logic [3:0] eu;    // expected ucount after the edge
    logic       ew;    // expected wrap after the edge
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input int sel, input logic r, input logic e, input logic u,
                              input logic s, input logic l, input logic [3:0] lv,
                              input logic [3:0] eu, input logic ew);
    vec_t v;
    v.sel = sel; v.rst = r; v.en = e; v.up = u; v.sat = s; v.ld = l;
    v.lv = lv; v.eu = eu; v.ew = ew;
    return v;
  endfunction

  task automatic apply_check(input vec_t v, input string tag);
    logic [3:0] u, d, last, ed;
    logic       t, w, et;
    rst = v.rst; en = v.en; up_dn = v.up; sat = v.sat; load = v.ld; load_val = v.lv;
    @(posedge clk);
    #1;
    n_vec++;
    case (v.sel)
      0:       begin u = ucount_a; d = dcount_a; t = tc_a; w = wrap_a; end
      1:       begin u = ucount_p; d = dcount_p; t = tc_p; w = wrap_p; end
      default: begin u = ucount_m; d = dcount_m; t = tc_m; w = wrap_m; end
    endcase
    last = (v.sel == 2) ? 4'd15 : 4'd9;
    ed   = last - v.eu;
    et   = v.up ? (v.eu == last) : (v.eu == 4'd0);
    if (u !== v.eu) begin
      n_bad++;
      $display("FAIL %s ucount: got %0d, want %0d", tag, u, v.eu);
    end
    if (d !== ed) begin
      n_bad++;
      $display("FAIL %s dcount: got %0d, want %0d", tag, d, ed);
    end
    if (t !== et) begin
      n_bad++;
      $display("FAIL %s tc: got %b, want %b", tag, t, et);
    end
    if (w !== v.ew) begin
      n_bad++;
      $display("FAIL %s wrap: got %b, want %b", tag, w, v.ew);
    end
    $display("%s sel=%0d rst=%b en=%b up=%b sat=%b ld=%b lv=%0d -> ucount=%0d wrap=%b",
             tag, v.sel, v.rst, v.en, v.up, v.sat, v.ld, v.lv, u, w);
  endtask

  initial begin
    // Mod-10: reset, tc follows direction, 11 up steps through a wrap.
    vq.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 11; k++) vq.push_back(mk(0, 0, 1, 1, 0, 0, 0, 4'(k % 10), k == 10));
    // Down with saturation from 2, then down wrap 0 -> 9.
    vq.push_back(mk(0, 0, 1, 1, 0, 1, 2, 2, 0));
    vq.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 0, 0, 0, 0, 9, 1));
    vq.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8, 0));
    vq.push_back(mk(0, 0, 1, 1, 0, 0, 0, 9, 0));
    // Loads: clamp, priority over step, boundary value 10, saturate at top.
    vq.push_back(mk(0, 0, 1, 1, 0, 1, 13, 9, 0));
    vq.push_back(mk(0, 0, 1, 1, 0, 1, 5, 5, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 1, 10, 9, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 0, 0, 9, 0));
    vq.push_back(mk(0, 0, 1, 0, 0, 1, 15, 9, 0));
    // Reset beats load; reset cancels a wrap step and clears a live wrap pulse.
    vq.push_back(mk(0, 0, 1, 1, 0, 1, 7, 7, 0));
    vq.push_back(mk(0, 1, 1, 1, 0, 1, 3, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 1, 9, 9, 0));
    vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 1, 9, 9, 0));
    vq.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0));
    // Prescale 3 with a two-cycle en gap mid-interval.
    vq.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
    begin
      logic [10:0] en_pat;
      logic [3:0]  exp_u [11];
      en_pat = 11'b11111001111;
      exp_u  = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3};
      for (int k = 0; k < 11; k++) vq.push_back(mk(1, 0, en_pat[k], 1, 0, 0, 0, exp_u[k], 0));
    end
    // Mod-16: top value, full-width wrap, down wrap.
    vq.push_back(mk(2, 1, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(2, 0, 0, 1, 0, 1, 14, 14, 0));
    vq.push_back(mk(2, 0, 1, 1, 0, 0, 0, 15, 0));
    vq.push_back(mk(2, 0, 1, 1, 0, 0, 0, 0, 1));
    vq.push_back(mk(2, 0, 1, 0, 0, 0, 0, 15, 1));
    vq.push_back(mk(2, 0, 1, 0, 0, 0, 0, 14, 0));

    for (int i = 0; i < vq.size(); i++) apply_check(vq[i], $sformatf("tab%0d", i));

    // Load restarts a partly elapsed prescale interval.
    apply_check(mk(1, 1, 0, 1, 0, 0, 0, 0, 0), "pld_rst");
    apply_check(mk(1, 0, 1, 1, 0, 0, 0, 0, 0), "pld_en0");
    apply_check(mk(1, 0, 1, 1, 0, 1, 4, 4, 0), "pld_load");
    apply_check(mk(1, 0, 1, 1, 0, 0, 0, 4, 0), "pld_en1");
    apply_check(mk(1, 0, 1, 1, 0, 0, 0, 4, 0), "pld_en2");
    apply_check(mk(1, 0, 1, 1, 0, 0, 0, 5, 0), "pld_en3");

    // Reset mid-interval abandons the partial prescale count.
    apply_check(mk(1, 0, 1, 1, 0, 0, 0, 5, 0), "prs_en0");
    apply_check(mk(1, 0, 1, 1, 0, 0, 0, 5, 0), "prs_en1");
    apply_check(mk(1, 1, 1, 1, 0, 0, 0, 0, 0), "prs_rst");
    apply_check(mk(1, 0, 1, 1, 0, 0, 0, 0, 0), "prs_en2");
    apply_check(mk(1, 0, 1, 1, 0, 0, 0, 0, 0), "prs_en3");
    apply_check(mk(1, 0, 1, 1, 0, 0, 0, 1, 0), "prs_en4");

    // Mod-16 full lap of 17 up steps: exactly one wrap, at 15 -> 0.
    apply_check(mk(2, 1, 0, 1, 0, 0, 0, 0, 0), "lap_rst");
    for (int k = 1; k <= 17; k++)
      apply_check(mk(2, 0, 1, 1, 0, 0, 0, 4'(k % 16), k == 16), $sformatf("lap%0d", k));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
